// File: rtl/frb_player_pkg.sv
// rtl/frb_player_pkg.sv - shared state type, DAC field offsets and default sizes for the FRB BRAM player
package frb_player_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // DAC sample word layout: channel 0 in the low half, channel 1 in the high half
  localparam int CH0_LSB  = 0;
  localparam int CH1_LSB  = 16;
  localparam int DAC_BITS = 14;

  localparam int DEF_ADDR_WIDTH   = 11;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_BRAM_LATENCY = 2;

endpackage

// File: rtl/frb_rate_div.sv
// rtl/frb_rate_div.sv - modulo-(div+1) counter giving one tick every div+1 enabled cycles
module frb_rate_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt;

  assign tick = en && (cnt == div);

  // count 0..div and wrap; clr restarts the period so the next tick is div cycles away
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == div) ? 16'd0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/frb_bram_player.sv
// rtl/frb_bram_player.sv - BRAM waveform playback sequencer feeding a held DAC sample (FRB_BRAM_PLAYER_BURST_CNT_EN adds burst_cnt)
module frb_bram_player
  import frb_player_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int BRAM_LATENCY = DEF_BRAM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] burst_len,
  input  logic [15:0]           rate_div,
  input  logic                  loop_en,
  input  logic [DATA_WIDTH-1:0] default_val,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] dac_val,
  output logic                  dac_valid,
  output logic                  busy,
`ifdef FRB_BRAM_PLAYER_BURST_CNT_EN
  output logic [15:0]           burst_cnt,
`endif
  output logic                  finish
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             rate_q;
  logic                    loop_q;
  logic [BRAM_LATENCY-1:0] vld_pipe;

  logic                  go;
  logic                  abort;
  logic                  tick;
  logic                  tail;
  logic                  issue;
  logic                  iss_last;
  logic                  iss_loop;
  logic                  drain_done;
  logic                  div_clr;
  logic                  div_en;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic [ADDR_WIDTH-1:0] iss_len;

  // bram_en is registered, so the read for the next cycle is decided one cycle early:
  // on the accepting start edge (address 0) and on every divider tick while running
  always_comb begin
    go         = (state == IDLE) && start && !stop && (burst_len != '0);
    abort      = stop && ((state == RUN) || (state == DRAIN));
    tail       = vld_pipe[BRAM_LATENCY-1];
    iss_addr   = go ? '0 : addr_q;
    iss_len    = go ? burst_len : len_q;
    iss_loop   = go ? loop_en : loop_q;
    iss_last   = (iss_addr == (iss_len - ONE));
    issue      = go || ((state == RUN) && tick && !stop);
    drain_done = (state == DRAIN) && !bram_en && (vld_pipe == '0) && tick;
    div_clr    = go || ((state == DRAIN) && tail);
    div_en     = (state == RUN) || (state == DRAIN);
  end

  frb_rate_div u_rate_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (div_en),
    .div  (rate_q),
    .tick (tick)
  );

  // playback FSM: issues reads, tracks in-flight reads, loads and holds DAC samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      rate_q    <= '0;
      loop_q    <= 1'b0;
      vld_pipe  <= '0;
      bram_addr <= '0;
      bram_en   <= 1'b0;
      dac_val   <= '0;
      dac_valid <= 1'b0;
      busy      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      bram_en   <= 1'b0;
      dac_valid <= 1'b0;
      finish    <= 1'b0;
      vld_pipe[0] <= bram_en;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end

      if (abort) begin
        // in-flight reads are dropped so no stale sample reaches the DAC
        state    <= IDLE;
        vld_pipe <= '0;
        busy     <= 1'b0;
        finish   <= 1'b1;
        dac_val  <= default_val;
      end else begin
        if (tail) begin
          dac_val   <= bram_dout;
          dac_valid <= 1'b1;
        end
        if (go) begin
          len_q  <= burst_len;
          rate_q <= rate_div;
          loop_q <= loop_en;
        end
        if (issue) begin
          bram_en   <= 1'b1;
          bram_addr <= iss_addr;
          busy      <= 1'b1;
          if (!iss_last) begin
            addr_q <= iss_addr + ONE;
            state  <= RUN;
          end else if (iss_loop) begin
            addr_q <= '0;
            state  <= RUN;
          end else begin
            state  <= DRAIN;
          end
        end
        case (state)
          IDLE:  dac_val <= default_val;
          DRAIN: begin
            if (drain_done) begin
              state   <= DONE;
              busy    <= 1'b0;
              finish  <= 1'b1;
              dac_val <= default_val;
            end
          end
          DONE: begin
            state   <= IDLE;
            dac_val <= default_val;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FRB_BRAM_PLAYER_BURST_CNT_EN
  // completed passes: each looped last-address issue or a normal end; aborts do not count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (go) begin
      burst_cnt <= '0;
    end else if (!abort && ((issue && iss_last && iss_loop) || drain_done)
                 && (burst_cnt != 16'hFFFF)) begin
      burst_cnt <= burst_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_frb_bram_player.sv
// tb/tb_frb_bram_player.sv - directed self-checking bench for frb_bram_player
module tb_frb_bram_player;

  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam logic [31:0] DEF = 32'h1234;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic [AW-1:0] burst_len;
  logic [15:0]   rate_div;
  logic          loop_en;
  logic [DW-1:0] default_val;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] dac_val;
  logic          dac_valid;
  logic          busy;
  logic          finish;
`ifdef FRB_BRAM_PLAYER_BURST_CNT_EN
  logic [15:0]   burst_cnt;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_stage;

  int nvec;
  int nerr;

  frb_bram_player #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .BRAM_LATENCY (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .burst_len   (burst_len),
    .rate_div    (rate_div),
    .loop_en     (loop_en),
    .default_val (default_val),
    .bram_addr   (bram_addr),
    .bram_en     (bram_en),
    .bram_dout   (bram_dout),
    .dac_val     (dac_val),
    .dac_valid   (dac_valid),
    .busy        (busy),
`ifdef FRB_BRAM_PLAYER_BURST_CNT_EN
    .burst_cnt   (burst_cnt),
`endif
    .finish      (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // two-cycle read latency BRAM model
  always @(posedge clk) begin
    rd_stage  <= mem[bram_addr];
    bram_dout <= rd_stage;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 3 * i;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    burst_len = '0; rate_div = '0; loop_en = 1'b0; default_val = DEF;
    #12;
    check("rst dac_val", dac_val, 0);
    check("rst bram_en", {31'd0, bram_en}, 0);
    check("rst bram_addr", {21'd0, bram_addr}, 0);
    check("rst busy", {31'd0, busy}, 0);
    check("rst finish", {31'd0, finish}, 0);
    check("rst dac_valid", {31'd0, dac_valid}, 0);
    rst = 1'b0;
    step();
    check("idle default", dac_val, DEF);

    // one-shot burst, len 4, no divide
    burst_len = 4; rate_div = 0; loop_en = 0;
    pulse_start();
    for (int c = 1; c <= 9; c++) begin
      check($sformatf("t1 en c%0d", c), {31'd0, bram_en}, (c <= 4) ? 1 : 0);
      if (c <= 4) check($sformatf("t1 addr c%0d", c), {21'd0, bram_addr}, c - 1);
      check($sformatf("t1 valid c%0d", c), {31'd0, dac_valid}, (c >= 4 && c <= 7) ? 1 : 0);
      if (c >= 4 && c <= 7) check($sformatf("t1 dac c%0d", c), dac_val, 3 * (c - 4));
      check($sformatf("t1 busy c%0d", c), {31'd0, busy}, (c <= 7) ? 1 : 0);
      check($sformatf("t1 finish c%0d", c), {31'd0, finish}, (c == 8) ? 1 : 0);
      if (c >= 8) check($sformatf("t1 default c%0d", c), dac_val, DEF);
      step();
    end

    // rate divide: len 3, each sample held 5 cycles
    burst_len = 3; rate_div = 4;
    pulse_start();
    for (int c = 1; c <= 20; c++) begin
      check($sformatf("t2 en c%0d", c), {31'd0, bram_en}, (c == 1 || c == 6 || c == 11) ? 1 : 0);
      check($sformatf("t2 valid c%0d", c), {31'd0, dac_valid}, (c == 4 || c == 9 || c == 14) ? 1 : 0);
      if (c >= 4 && c <= 18) check($sformatf("t2 dac c%0d", c), dac_val, 3 * ((c - 4) / 5));
      if (c >= 19) check($sformatf("t2 default c%0d", c), dac_val, DEF);
      check($sformatf("t2 busy c%0d", c), {31'd0, busy}, (c <= 18) ? 1 : 0);
      check($sformatf("t2 finish c%0d", c), {31'd0, finish}, (c == 19) ? 1 : 0);
      step();
    end

    // looped playback, len 2, then abort by stop
    burst_len = 2; rate_div = 0; loop_en = 1;
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("t3 en c%0d", c), {31'd0, bram_en}, 1);
      check($sformatf("t3 addr c%0d", c), {21'd0, bram_addr}, (c - 1) % 2);
      check($sformatf("t3 finish c%0d", c), {31'd0, finish}, 0);
      if (c >= 4) check($sformatf("t3 dac c%0d", c), dac_val, 3 * ((c - 4) % 2));
`ifdef FRB_BRAM_PLAYER_BURST_CNT_EN
      check($sformatf("t3 bcnt c%0d", c), {16'd0, burst_cnt}, c / 2);
`endif
      if (c < 8) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t3 stop dac", dac_val, DEF);
    check("t3 stop finish", {31'd0, finish}, 1);
    check("t3 stop valid", {31'd0, dac_valid}, 0);
    check("t3 stop busy", {31'd0, busy}, 0);
    check("t3 stop en", {31'd0, bram_en}, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("t3 flush valid %0d", c), {31'd0, dac_valid}, 0);
      check($sformatf("t3 flush finish %0d", c), {31'd0, finish}, 0);
      check($sformatf("t3 flush dac %0d", c), dac_val, DEF);
    end
`ifdef FRB_BRAM_PLAYER_BURST_CNT_EN
    check("t3 bcnt after stop", {16'd0, burst_cnt}, 4);
`endif

    // invalid and conflicting starts
    burst_len = 0; loop_en = 0;
    pulse_start();
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t4 len0 busy %0d", c), {31'd0, busy}, 0);
      check($sformatf("t4 len0 en %0d", c), {31'd0, bram_en}, 0);
      step();
    end
    burst_len = 4;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("t4 ss busy %0d", c), {31'd0, busy}, 0);
      check($sformatf("t4 ss en %0d", c), {31'd0, bram_en}, 0);
      check($sformatf("t4 ss finish %0d", c), {31'd0, finish}, 0);
      step();
    end

    // start pulsed while running with different inputs has no effect
    burst_len = 3; rate_div = 1; loop_en = 0;
    pulse_start();
    for (int c = 1; c <= 11; c++) begin
      check($sformatf("t4 run en c%0d", c), {31'd0, bram_en}, (c == 1 || c == 3 || c == 5) ? 1 : 0);
      if (c == 1 || c == 3 || c == 5) check($sformatf("t4 run addr c%0d", c), {21'd0, bram_addr}, (c - 1) / 2);
      check($sformatf("t4 run busy c%0d", c), {31'd0, busy}, (c <= 9) ? 1 : 0);
      check($sformatf("t4 run finish c%0d", c), {31'd0, finish}, (c == 10) ? 1 : 0);
      start = (c == 2);
      if (c == 2) begin
        burst_len = 7; rate_div = 0; loop_en = 1;
      end
      step();
    end
    start = 1'b0;

    // asynchronous reset in the middle of a looped run
    burst_len = 4; rate_div = 0; loop_en = 1;
    pulse_start();
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    check("t5 rst bram_en", {31'd0, bram_en}, 0);
    check("t5 rst bram_addr", {21'd0, bram_addr}, 0);
    check("t5 rst dac_val", dac_val, 0);
    check("t5 rst dac_valid", {31'd0, dac_valid}, 0);
    check("t5 rst busy", {31'd0, busy}, 0);
    check("t5 rst finish", {31'd0, finish}, 0);
`ifdef FRB_BRAM_PLAYER_BURST_CNT_EN
    check("t5 rst bcnt", {16'd0, burst_cnt}, 0);
`endif
    #1 rst = 1'b0;
    step();
    check("t5 post default", dac_val, DEF);
    burst_len = 2; loop_en = 0;
    pulse_start();
    for (int c = 1; c <= 6; c++) begin
      if (c <= 2) check($sformatf("t5 addr c%0d", c), {21'd0, bram_addr}, c - 1);
      if (c == 4 || c == 5) check($sformatf("t5 dac c%0d", c), dac_val, 3 * (c - 4));
      check($sformatf("t5 finish c%0d", c), {31'd0, finish}, (c == 6) ? 1 : 0);
      step();
    end
`ifdef FRB_BRAM_PLAYER_BURST_CNT_EN
    check("t5 bcnt done", {16'd0, burst_cnt}, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
